trace_fetch_arbiter: RTL and testbench
======================================

// Module: trace_fetch_arbiter
// PURPOSE
//  Shares one trace BRAM (16-bit addr, 16-bit entries) between NUM_CORES core models of the multicore simulator.
//  The BRAM address space is split into equal per-core regions; one per-core read pointer walks each region.
//  A round-robin arbiter grants one read at a time, waits out the BRAM latency and returns the entry to that core.
//  Replaces per-core trace readers: one BRAM port, fair interleaving, per-core done flags.
// PARAMETERS
//  NUM_CORES  4   requesters; power of two, >=2
//  ADDR_W     16  BRAM address width
//  DATA_W     16  trace entry width
//  BRAM_LAT   1   BRAM read latency, cycles from addr sampled to dout valid (1..4)
//  localparam CORE_W = log2(NUM_CORES); REGION_W = ADDR_W-CORE_W; core c region base = {c, REGION_W'b0}
// PORTS
//  clk        in   1               clock; all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  start      in   1               pulse: clear pointers/done, begin serving (ignored while busy)
//  req        in   NUM_CORES       per-core read request, level, held until own rsp_valid
//  rsp_valid  out  NUM_CORES       one-hot, 1-cycle pulse: rsp_data belongs to that core
//  rsp_data   out  DATA_W          registered trace entry, stable until next rsp_valid
//  done       out  NUM_CORES       core's region fully consumed (sticky until start/rst)
//  busy       out  1               controller not in IDLE
//  bram_ena   out  1               BRAM enable
//  bram_addr  out  ADDR_W          BRAM address
//  bram_dout  in   DATA_W          BRAM read data
// BEHAVIOUR
//  Reset: state IDLE; rsp_valid=0, rsp_data=0, done=0, busy=0, bram_ena=0, bram_addr=0; all ptr=0; last_grant=NUM_CORES-1.
//  FSM IDLE -> ARB -> WAIT -> RESP -> ARB ...
//   IDLE: start=1 -> clear every ptr and done, go ARB.
//   ARB : eligible = req & ~done. None -> stay ARB. Else grant g = first eligible scanning
//         last_grant+1, +2, ... (mod NUM_CORES). Register bram_addr={g,ptr[g]}, bram_ena=1, load wait cnt=BRAM_LAT, go WAIT.
//   WAIT: bram_ena=0 (exactly one enable pulse per grant); decrement cnt; at cnt==0 sample bram_dout -> rsp_data, go RESP.
//   RESP: rsp_valid[g]=1 one cycle; ptr[g]++ ; last_grant=g; go ARB (or IDLE, see below).
//  Latency: grant in ARB cycle T -> rsp_valid at T+BRAM_LAT+2. Peak throughput one entry per BRAM_LAT+3 cycles.
//  Ordering: per core, entries returned in strictly increasing address order; no entry skipped or repeated.
//  req dropped after grant: response still delivered; req is not re-sampled until ARB.
//  req from a done core: never granted, no rsp_valid.
//  start while busy: ignored. rst at any state: immediate return to reset values, in-flight read discarded.
//  Pointer width REGION_W, unsigned; end-of-region = ptr all ones served.
// CONFIGURATION
//  Macro TRACE_WRAP_EN:
//   defined   : after serving ptr all-ones, ptr wraps to 0; done never asserts; FSM never leaves ARB except via rst.
//   undefined : after serving ptr all-ones, done[g]<=1 in RESP cycle, ptr holds; when done becomes all ones, RESP -> IDLE
//               (busy falls the following cycle); a new start re-arms.
// STRUCTURE
//  Package trace_arb_pkg: state enum {IDLE,ARB,WAIT,RESP}; CORE_W/REGION_W helper functions; BRAM_LAT max constant.
//  Sub-module rr_arbiter (NUM_CORES): combinational rotating-priority pick from eligible mask and last_grant;
//   outputs grant_valid and grant index. Pointers, FSM and BRAM interface stay in trace_fetch_arbiter.
// TESTING (bench: BRAM model with BRAM_LAT, entry = address value; NUM_CORES=4, ADDR_W=16 -> REGION_W=14)
//  Reset then idle: rst 2 cycles, no start -> all outputs 0, busy=0, no bram_ena for 20 cycles.
//  Single core: start, req=4'b0001 held -> rsp_data 0x0000,0x0001,0x0002 on rsp_valid=0001, spaced BRAM_LAT+3 cycles,
//   first rsp_valid exactly BRAM_LAT+2 cycles after the first ARB cycle.
//  Fairness: req=4'b1111 held -> grant order cores 0,1,2,3,0..; rsp_data 0x0000,0x4000,0x8000,0xC000,0x0001.
//  Region end (no TRACE_WRAP_EN): preload ptr[2] path by running core 2 alone to 0xBFFF -> done=4'b0100 same cycle
//   as that rsp_valid; further req[2] never answered; cores 0/1/3 unaffected.
//  Region end (TRACE_WRAP_EN): core 3 after 0xFFFF -> next rsp_data 0xC000, done stays 0.
//  Reset mid-read: rst asserted in WAIT -> next cycle all outputs at reset values, no rsp_valid; start restarts core 0 at 0x0000.

Source files
------------

// File: rtl/trace_arb_pkg.sv
// Shared types and sizing helpers for the trace fetch arbiter.
//   state_e      : controller states IDLE -> ARB -> WAIT -> RESP
//   BRAM_LAT_MAX : largest supported BRAM read latency (sizes the wait counter)
//   core_w()     : bits needed to index a core
//   region_w()   : bits of the per-core pointer (address bits left after the core index)
package trace_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int BRAM_LAT_MAX = 4;

  function automatic int core_w(input int num_cores);
    return $clog2(num_cores);
  endfunction

  function automatic int region_w(input int addr_w, input int num_cores);
    return addr_w - $clog2(num_cores);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   eligible    in  NUM_CORES  cores that may be granted this cycle
//   last_grant  in  CORE_W     most recently served core (lowest priority now)
//   grant_valid out 1          at least one core is eligible
//   grant_idx   out CORE_W     first eligible core after last_grant (wrapping)
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W    = 2
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [CORE_W-1:0]    last_grant,
  output logic                 grant_valid,
  output logic [CORE_W-1:0]    grant_idx
);

  logic [CORE_W-1:0] cand_s;

  // Scan from farthest to nearest so the nearest eligible core after last_grant wins.
  // NUM_CORES is a power of two, so the CORE_W-bit add wraps modulo NUM_CORES.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand_s      = last_grant;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand_s      = last_grant + CORE_W'(k);
      grant_valid = grant_valid | eligible[cand_s];
      grant_idx   = eligible[cand_s] ? cand_s : grant_idx;
    end
  end

endmodule

// File: rtl/trace_fetch_arbiter.sv
// Shares one trace BRAM between NUM_CORES core models. Each core owns an equal
// address region {core, ptr}; a round-robin arbiter grants one read at a time,
// waits out the BRAM latency and returns the entry to the granted core.
//
// Ports:
//   clk        in   1          clock, posedge
//   rst        in   1          synchronous active-high reset
//   start      in   1          pulse: clear pointers/done and begin serving (ignored while busy)
//   req        in   NUM_CORES  per-core read request, held until own rsp_valid
//   rsp_valid  out  NUM_CORES  one-hot single-cycle response strobe
//   rsp_data   out  DATA_W     registered trace entry, stable until next rsp_valid
//   done       out  NUM_CORES  sticky: core's region fully consumed
//   busy       out  1          controller not in IDLE
//   bram_ena   out  1          BRAM enable, one pulse per grant
//   bram_addr  out  ADDR_W     BRAM address
//   bram_dout  in   DATA_W     BRAM read data
//
// Build option: macro TRACE_WRAP_EN makes pointers wrap at the end of their
// region; done never asserts and the controller stays in ARB until reset.
module trace_fetch_arbiter
  import trace_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BRAM_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [NUM_CORES-1:0] done,
  output logic                 busy,
  output logic                 bram_ena,
  output logic [ADDR_W-1:0]    bram_addr,
  input  logic [DATA_W-1:0]    bram_dout
);

  localparam int CORE_W   = core_w(NUM_CORES);
  localparam int REGION_W = region_w(ADDR_W, NUM_CORES);
  localparam int CNT_W    = $clog2(BRAM_LAT_MAX + 1);

  localparam logic [NUM_CORES-1:0] ONE_HOT_BASE = {{(NUM_CORES-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     LAT_LOAD     = CNT_W'(BRAM_LAT);
  localparam logic [CORE_W-1:0]    LAST_CORE    = CORE_W'(NUM_CORES - 1);
`ifndef TRACE_WRAP_EN
  localparam logic [REGION_W-1:0]  PTR_LAST     = {REGION_W{1'b1}};
`endif

  state_e                 state_r;
  logic [REGION_W-1:0]    ptr_r [NUM_CORES];
  logic [NUM_CORES-1:0]   done_r;
  logic [NUM_CORES-1:0]   rsp_valid_r;
  logic [DATA_W-1:0]      rsp_data_r;
  logic                   busy_r;
  logic                   bram_ena_r;
  logic [ADDR_W-1:0]      bram_addr_r;
  logic [CORE_W-1:0]      last_grant_r;
  logic [CORE_W-1:0]      gnt_r;
  logic [CNT_W-1:0]       cnt_r;

  logic [NUM_CORES-1:0]   eligible_s;
  logic                   grant_valid_s;
  logic [CORE_W-1:0]      grant_idx_s;

  // Exhausted cores are never offered to the arbiter.
  assign eligible_s = req & ~done_r;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .CORE_W    (CORE_W)
  ) u_rr_arbiter (
    .eligible    (eligible_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign bram_ena  = bram_ena_r;
  assign bram_addr = bram_addr_r;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      for (int i = 0; i < NUM_CORES; i++) ptr_r[i] <= '0;
      done_r       <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      busy_r       <= 1'b0;
      bram_ena_r   <= 1'b0;
      bram_addr_r  <= '0;
      last_grant_r <= LAST_CORE;
      gnt_r        <= '0;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= '0;
          bram_ena_r  <= 1'b0;
          if (start) begin
            for (int i = 0; i < NUM_CORES; i++) ptr_r[i] <= '0;
            done_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= ARB;
          end
        end
        ARB: begin
          rsp_valid_r <= '0;
          if (grant_valid_s) begin
            bram_addr_r <= {grant_idx_s, ptr_r[grant_idx_s]};
            bram_ena_r  <= 1'b1;
            gnt_r       <= grant_idx_s;
            cnt_r       <= LAT_LOAD;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          bram_ena_r <= 1'b0;
          if (cnt_r == {CNT_W{1'b0}}) begin
            rsp_data_r  <= bram_dout;
            rsp_valid_r <= ONE_HOT_BASE << gnt_r;
`ifndef TRACE_WRAP_EN
            // done is raised with the final entry so it is visible alongside its rsp_valid.
            if (ptr_r[gnt_r] == PTR_LAST) done_r[gnt_r] <= 1'b1;
`endif
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid_r  <= '0;
          last_grant_r <= gnt_r;
`ifdef TRACE_WRAP_EN
          ptr_r[gnt_r] <= ptr_r[gnt_r] + REGION_W'(1);
          state_r      <= ARB;
`else
          // Pointer parks on the last entry once the region is consumed.
          if (ptr_r[gnt_r] != PTR_LAST) ptr_r[gnt_r] <= ptr_r[gnt_r] + REGION_W'(1);
          if (&done_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= ARB;
          end
`endif
        end
        default: begin
          rsp_valid_r <= '0;
          bram_ena_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_fetch_arbiter.sv
// Directed self-checking bench for trace_fetch_arbiter (NUM_CORES=4, ADDR_W=16,
// BRAM_LAT=1). The BRAM model returns the address as the entry value.
module tb_trace_fetch_arbiter;

  localparam int NUM_CORES = 4;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BRAM_LAT  = 1;
  localparam int REGION_N  = 16384;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] rsp_valid;
  logic [DATA_W-1:0]    rsp_data;
  logic [NUM_CORES-1:0] done;
  logic                 busy;
  logic                 bram_ena;
  logic [ADDR_W-1:0]    bram_addr;
  logic [DATA_W-1:0]    bram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_fetch_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BRAM_LAT  (BRAM_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .req       (req),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .done      (done),
    .busy      (busy),
    .bram_ena  (bram_ena),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout)
  );

  // BRAM model: address sampled on enable, data out BRAM_LAT cycles later.
  logic [DATA_W-1:0] pipe [BRAM_LAT];
  always @(posedge clk) begin
    if (bram_ena) pipe[0] <= bram_addr;
    for (int i = 1; i < BRAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_dout = pipe[BRAM_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until a response appears (bounded); report cycles taken and enable pulses seen.
  task automatic wait_rsp(output int cyc, output int enas, output logic timeout);
    cyc = 0;
    enas = 0;
    do begin
      tick();
      cyc++;
      if (bram_ena) enas++;
    end while (rsp_valid == '0 && cyc < 60);
    timeout = (rsp_valid == '0);
  endtask

  initial begin
    int   cyc;
    int   enas;
    logic to;
    int   quiet;
    int   errs;
    int   k;
    logic [3:0]  exp_core [5];
    logic [15:0] exp_data [5];
    logic [3:0]  tail_core [3];
    logic [15:0] tail_data [3];

    // ---- Reset, then idle with no start ----
    rst = 1'b1; start = 1'b0; req = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_done",      done,      0);
    check("rst_busy",      busy,      0);
    check("rst_bram_ena",  bram_ena,  0);
    check("rst_bram_addr", bram_addr, 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bram_ena || busy || rsp_valid != '0) quiet++;
    end
    check("idle_activity", quiet, 0);

    // ---- Single core: latency and spacing ----
    req = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    check("single_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      wait_rsp(cyc, enas, to);
      check("single_timeout", to, 0);
      check("single_cycles", cyc, (i == 0) ? BRAM_LAT + 2 : BRAM_LAT + 3);
      check("single_enas", enas, 1);
      check("single_valid", rsp_valid, 4'b0001);
      check("single_data", rsp_data, i);
    end
    req = '0;
    // start while busy must not clear pointers
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    req = 4'b0001;
    wait_rsp(cyc, enas, to);
    check("busy_start_timeout", to, 0);
    check("busy_start_data", rsp_data, 16'h0003);
    req = '0;

    // ---- Fairness with all cores requesting ----
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    exp_core[0] = 4'b0001; exp_data[0] = 16'h0000;
    exp_core[1] = 4'b0010; exp_data[1] = 16'h4000;
    exp_core[2] = 4'b0100; exp_data[2] = 16'h8000;
    exp_core[3] = 4'b1000; exp_data[3] = 16'hC000;
    exp_core[4] = 4'b0001; exp_data[4] = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(cyc, enas, to);
      check("fair_timeout", to, 0);
      check("fair_cycles", cyc, (i == 0) ? BRAM_LAT + 2 : BRAM_LAT + 3);
      check("fair_valid", rsp_valid, exp_core[i]);
      check("fair_data", rsp_data, exp_data[i]);
    end

    // ---- Reset in the middle of a read ----
    req = 4'b0001;
    tick();
    tick();
    check("mid_bram_ena", bram_ena, 1);
    check("mid_bram_addr", bram_addr, 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data",  rsp_data,  0);
    check("mid_rst_done",  done,      0);
    check("mid_rst_busy",  busy,      0);
    check("mid_rst_ena",   bram_ena,  0);
    check("mid_rst_addr",  bram_addr, 0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bram_ena || busy || rsp_valid != '0) quiet++;
    end
    check("mid_rst_quiet", quiet, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rsp(cyc, enas, to);
    check("restart_timeout", to, 0);
    check("restart_cycles", cyc, BRAM_LAT + 2);
    check("restart_valid", rsp_valid, 4'b0001);
    check("restart_data", rsp_data, 16'h0000);
    req = '0;

`ifdef TRACE_WRAP_EN
    // ---- Region end with wrap: core 3 walks 0xC000..0xFFFF then wraps ----
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    errs = 0;
    k = 0;
    while (k < REGION_N && errs == 0) begin
      wait_rsp(cyc, enas, to);
      if (to || rsp_valid != 4'b1000 || rsp_data != 16'(16'hC000 + k) || done != '0) begin
        errs++;
        $error("FAIL wrap_walk index=%0d observed=0x%0h expected=0x%0h", k, rsp_data, 16'(16'hC000 + k));
      end
      k++;
    end
    check("wrap_walk_errs", errs, 0);
    check("wrap_last_data", rsp_data, 16'hFFFF);
    wait_rsp(cyc, enas, to);
    check("wrap_timeout", to, 0);
    check("wrap_data", rsp_data, 16'hC000);
    check("wrap_done", done, 0);
    check("wrap_busy", busy, 1);
    req = '0;
`else
    // ---- Region end: core 2 walks 0x8000..0xBFFF, then is exhausted ----
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    errs = 0;
    k = 0;
    while (k < REGION_N && errs == 0) begin
      wait_rsp(cyc, enas, to);
      if (to || rsp_valid != 4'b0100 || rsp_data != 16'(16'h8000 + k) ||
          done != ((k == REGION_N - 1) ? 4'b0100 : 4'b0000)) begin
        errs++;
        $error("FAIL region_walk index=%0d observed=0x%0h expected=0x%0h", k, rsp_data, 16'(16'h8000 + k));
      end
      k++;
    end
    check("region_walk_errs", errs, 0);
    check("region_last_data", rsp_data, 16'hBFFF);
    check("region_done", done, 4'b0100);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bram_ena || rsp_valid != '0) quiet++;
    end
    check("region_done_ignored", quiet, 0);
    check("region_busy", busy, 1);
    check("region_done_sticky", done, 4'b0100);
    req = 4'b1011;
    tail_core[0] = 4'b1000; tail_data[0] = 16'hC000;
    tail_core[1] = 4'b0001; tail_data[1] = 16'h0000;
    tail_core[2] = 4'b0010; tail_data[2] = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      wait_rsp(cyc, enas, to);
      check("others_timeout", to, 0);
      check("others_valid", rsp_valid, tail_core[i]);
      check("others_data", rsp_data, tail_data[i]);
    end
    req = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
